// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: parity mode encodings, parity checker states, prescale floor.
package uart_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    // Smallest legal oversampling ratio; keeps MID+2 inside the PRESCALE_W range.
    localparam int MIN_PRESCALE = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SAMPLE = 2'b01,
        ST_HOLD   = 2'b10
    } par_state_e;

endpackage

// File: rtl/uart_maj3.sv
// Combinational 3-input majority voter for oversampled UART bits.
// Latency 0; no flow control.
module uart_maj3
    import uart_pkg::*;
(
    input  logic [2:0] votes,
    output logic       maj
);

    assign maj = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);

endmodule

// File: rtl/uart_rx_par_chk.sv
// UART RX parity checker: 3-sample majority vote on the parity bit, even/odd/mark/space modes.
// Result strobe one cycle after edge_count hits MID+2; no backpressure. Error counter under UART_PAR_ERR_CNT_EN.
module uart_rx_par_chk
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            par_mode,
    input  logic                  parity_check_en,
    input  logic                  sampled_bit,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [PRESCALE_W-1:0] edge_count,
    input  logic [DATA_WIDTH-1:0] P_data,
    output logic                  par_err,
    output logic                  par_done,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    input  logic                  err_cnt_clr
);

    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] s0;
    logic [PRESCALE_W-1:0] s1;
    logic [PRESCALE_W-1:0] s2;
    logic [PRESCALE_W-1:0] dec;

    assign mid = Prescale >> 1;
    assign s0  = mid - PRESCALE_W'(1);
    assign s1  = mid;
    assign s2  = mid + PRESCALE_W'(1);
    assign dec = mid + PRESCALE_W'(2);

    par_state_e state_q, state_d;
    logic [2:0] vote_q, vote_d;
    logic       par_err_q, par_err_d;
    logic       par_done_q, par_done_d;
    logic       rx_bit;
    logic       exp_bit;

    uart_maj3 u_maj3 (
        .votes (vote_q),
        .maj   (rx_bit)
    );

    always_comb begin
        exp_bit = 1'b0;
        case (par_mode)
            PAR_EVEN:  exp_bit = ^P_data;
            PAR_ODD:   exp_bit = ~^P_data;
            PAR_MARK:  exp_bit = 1'b1;
            PAR_SPACE: exp_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        vote_d     = vote_q;
        par_err_d  = par_err_q;
        par_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (parity_check_en) begin
                    state_d = ST_SAMPLE;
                    vote_d  = 3'b000;
                    if (edge_count == s0) vote_d[0] = sampled_bit;
                end
            end
            ST_SAMPLE: begin
                // An enable drop is an abort: the previous result stays visible.
                if (!parity_check_en) begin
                    state_d = ST_IDLE;
                end else begin
                    if (edge_count == s0) vote_d[0] = sampled_bit;
                    if (edge_count == s1) vote_d[1] = sampled_bit;
                    if (edge_count == s2) vote_d[2] = sampled_bit;
                    if (edge_count == dec) begin
                        par_err_d  = (rx_bit != exp_bit);
                        par_done_d = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!parity_check_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            vote_q     <= 3'b000;
            par_err_q  <= 1'b0;
            par_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vote_q     <= vote_d;
            par_err_q  <= par_err_d;
            par_done_q <= par_done_d;
        end
    end

    assign par_err  = par_err_q;
    assign par_done = par_done_q;

`ifdef UART_PAR_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Clear takes priority over a coincident increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (par_done_q && par_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_cnt_clr;
    assign unused_err_cnt_clr = err_cnt_clr;
    assign err_cnt            = '0;
`endif

endmodule

// File: tb/tb_uart_rx_par_chk.sv
// Directed plus randomized frames for uart_rx_par_chk, checked against a parity/majority reference model.
module tb_uart_rx_par_chk;

    localparam int PW = 6;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    par_mode;
    logic          parity_check_en;
    logic          sampled_bit;
    logic [PW-1:0] prescale;
    logic [PW-1:0] edge_count;
    logic [7:0]    p_data;
    logic [4:0]    p_data5;
    logic          err_cnt_clr;
    logic          par_err, par_done, par_err5, par_done5;
    logic [CW-1:0] err_cnt, err_cnt5;

    int total = 0;
    int bad   = 0;
    logic exp_err  = 1'b0;
    logic exp_err5 = 1'b0;
    int   exp_cnt  = 0;

    always #5 clk = ~clk;

    uart_rx_par_chk #(.DATA_WIDTH(8), .PRESCALE_W(PW), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .par_mode(par_mode), .parity_check_en(parity_check_en),
        .sampled_bit(sampled_bit), .Prescale(prescale), .edge_count(edge_count),
        .P_data(p_data), .par_err(par_err), .par_done(par_done),
        .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
    );

    uart_rx_par_chk #(.DATA_WIDTH(5), .PRESCALE_W(PW), .ERR_CNT_W(CW)) dut5 (
        .clk(clk), .rst(rst), .par_mode(par_mode), .parity_check_en(parity_check_en),
        .sampled_bit(sampled_bit), .Prescale(prescale), .edge_count(edge_count),
        .P_data(p_data5), .par_err(par_err5), .par_done(par_done5),
        .err_cnt(err_cnt5), .err_cnt_clr(err_cnt_clr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic expected_parity(input logic [1:0] mode, input int ones);
        case (mode)
            2'b00:   return logic'(ones % 2);
            2'b01:   return logic'((ones + 1) % 2);
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One parity-bit period (two if wrap) with edge_count stepping 0..ps-1 per clock.
    task automatic frame(input logic [1:0] mode, input logic [7:0] data, input logic [4:0] d5,
                         input logic [2:0] votes, input int ps, input int drop_at,
                         input int rst_at, input bit wrap, input bit clr_dec);
        int   mid, dec, n;
        logic rx, e8, e5;
        bit   aborted, done_exp;
        mid = ps / 2;
        dec = mid + 2;
        n   = wrap ? 2 * ps : ps;
        rx  = ($countones(votes) >= 2);
        e8  = expected_parity(mode, $countones(data));
        e5  = expected_parity(mode, $countones(d5));
        aborted = 1'b0;
        par_mode = mode;
        p_data   = data;
        p_data5  = d5;
        prescale = PW'(ps);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            done_exp = !aborted && (k > 0) && ((k - 1) == dec);
            if (done_exp) begin
                exp_err  = rx ^ e8;
                exp_err5 = rx ^ e5;
            end
            chk("par_done", {7'b0, par_done}, {7'b0, done_exp});
            chk("par_done5", {7'b0, par_done5}, {7'b0, done_exp});
            chk("par_err", {7'b0, par_err}, {7'b0, exp_err});
            chk("par_err5", {7'b0, par_err5}, {7'b0, exp_err5});
            chk("err_cnt", {6'b0, err_cnt}, 8'(exp_cnt));
            rst = 1'b1;
            if (k == drop_at || k == rst_at) aborted = 1'b1;
            parity_check_en = !aborted && (k < n);
            edge_count = PW'(k % ps);
            if ((k % ps) == mid - 1)      sampled_bit = votes[0];
            else if ((k % ps) == mid)     sampled_bit = votes[1];
            else if ((k % ps) == mid + 1) sampled_bit = votes[2];
            else                          sampled_bit = 1'($urandom_range(0, 1));
            err_cnt_clr = clr_dec && (k == dec || k == dec + 1);
`ifdef UART_PAR_ERR_CNT_EN
            if (err_cnt_clr)
                exp_cnt = 0;
            else if (done_exp && exp_err && exp_cnt < (1 << CW) - 1)
                exp_cnt = exp_cnt + 1;
`endif
            if (k == rst_at) begin
                rst = 1'b0;
                #1;
                exp_err  = 1'b0;
                exp_err5 = 1'b0;
                exp_cnt  = 0;
                chk("rst_par_err", {7'b0, par_err}, 8'h00);
                chk("rst_par_done", {7'b0, par_done}, 8'h00);
                chk("rst_err_cnt", {6'b0, err_cnt}, 8'h00);
            end
        end
        err_cnt_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        par_mode = 2'b00;
        parity_check_en = 1'b0;
        sampled_bit = 1'b0;
        prescale = PW'(8);
        edge_count = '0;
        p_data = '0;
        p_data5 = '0;
        err_cnt_clr = 1'b0;
        #12;
        chk("reset_par_err", {7'b0, par_err}, 8'h00);
        chk("reset_par_done", {7'b0, par_done}, 8'h00);
        chk("reset_err_cnt", {6'b0, err_cnt}, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // mode, data, data5, votes, prescale, drop_at, rst_at, wrap, clr
        frame(2'b00, 8'hA5, 5'b00000, 3'b000, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b01, 8'hA5, 5'b00000, 3'b000, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b00, 8'hA5, 5'b00000, 3'b000, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b00, 8'h01, 5'b00001, 3'b101, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b00, 8'h01, 5'b00001, 3'b010, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b10, 8'h3C, 5'b01010, 3'b111, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b11, 8'h3C, 5'b01010, 3'b111, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b00, 8'h00, 5'b10110, 3'b111, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b11, 8'h00, 5'b10110, 3'b111, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b00, 8'h00, 5'b00000, 3'b000, 8, 4, -1, 1'b0, 1'b0);
        frame(2'b01, 8'hA5, 5'b00000, 3'b000, 8, -1, 5, 1'b0, 1'b0);
        frame(2'b01, 8'hA5, 5'b00000, 3'b000, 10, -1, -1, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++)
            frame(2'b01, 8'hA5, 5'b00011, 3'b000, 8, -1, -1, 1'b0, 1'b0);
        frame(2'b01, 8'hA5, 5'b00011, 3'b000, 8, -1, -1, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int ps, drop;
            ps   = 2 * $urandom_range(4, 15);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ps / 2 + 2) : -1;
            frame(2'($urandom), 8'($urandom), 5'($urandom), 3'($urandom), ps, drop, -1,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
